bmu_soft_pipe: RTL
==================

// Module: bmu_soft_pipe
// PURPOSE
//  Parametrised soft-decision branch metric unit for the Viterbi decoder; feeds the ACS array.
//  Takes one received symbol group (N_SYM soft values, rate 1/N_SYM) per transfer.
//  Emits the distance to every one of the 2**N_SYM codewords.
//  Adds erasure/puncture masking and a 2-stage elastic valid/ready pipeline with frame tagging.
//  With SOFT_W=1 the metrics reduce to the hard-decision Hamming distance.
// PARAMETERS
//  N_SYM   2  code symbols per trellis step (rate 1/N_SYM), 2..4
//  SOFT_W  3  soft quantisation bits per symbol; offset-binary: 0 = strong '0', MAX=2**SOFT_W-1 = strong '1'
//  BM_W    SOFT_W+$clog2(N_SYM)  metric width (derived localparam, not overridable)
//  N_CW    2**N_SYM  number of codewords/metrics (derived localparam)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  in_valid   in   1             symbol group valid
//  in_ready   out  1             unit can accept a symbol group
//  sym_i      in   N_SYM*SOFT_W  soft symbols; sym j at [j*SOFT_W +: SOFT_W]
//  erase_i    in   N_SYM         1 = symbol j punctured/erased, contributes 0
//  last_i     in   1             final symbol group of frame
//  out_valid  out  1             metrics valid
//  out_ready  in   1             downstream (ACS) accepts metrics
//  bm_o       out  N_CW*BM_W     metric of codeword c at [c*BM_W +: BM_W]
//  last_o     out  1             last_i tag aligned with bm_o
//  step_cnt_o out  16            groups emitted in current frame incl. present one (1-based)
// BEHAVIOUR
//  - Transfer occurs on a cycle where valid&&ready; no other cycle moves data.
//  - Codeword c, bit j = c[j] is the expected value of symbol j.
//  - Per-symbol distance d(j,b): b=0 -> sym_j; b=1 -> MAX-sym_j; forced 0 if erase_i[j].
//  - bm[c] = sum_j d(j,c[j]), unsigned, BM_W wide; max N_SYM*MAX always fits, no saturation.
//  - S1 (input accept): registers the 2*N_SYM masked distances, last tag, and valid.
//  - S2: registers the N_CW sums, last tag, and step count; S2 outputs drive the ports directly.
//  - Latency: 2 cycles from input transfer to out_valid when unstalled.
//  - Throughput: 1 group/cycle.
//  - Each stage loads when it is empty or its content moves on the same cycle.
//    s2_adv = !s2_v || out_ready; s1_adv = !s1_v || s2_adv; in_ready = s1_adv.
//  - in_ready is combinational from out_ready (no skid); S2 holds all outputs stable while out_valid && !out_ready.
//  - S2 empties when out_ready && !S1 valid; out_valid drops; bm_o keeps its last value (don't-care).
//  - step_cnt: increments on each S2 load.
//    After a load carrying last=1, the next load restarts at 1.
//    Wraps 65535 -> 0 with no flag.
//  - Reset values: s1/s2 valid=0, out_valid=0, last_o=0, bm_o=0, step_cnt_o=0; in_ready=1 the cycle after reset drops.
//  - Reset mid-operation discards both stages with no partial output.
//    An input presented during reset is not accepted.
//  - Transfer with all erase_i=1: every bm=0 (valid, not dropped).
//  - in_valid while in_ready=0 has no effect; the source must hold data (AXI-style).
// STRUCTURE
//  - Shared package viterbi_pkg holds:
//    - N_SYM/SOFT_W defaults;
//    - function bm_w(n,s);
//    - function sym_dist(sym,bit,erase), used by both RTL and bench model.
//  - One sub-module: bmu_pipe_stage, a generic valid/ready register slice (data width param).
//    It is instantiated twice; the adder tree is inline generate loops.
// TESTING (N_SYM=2, SOFT_W=3 unless noted)
//  1. Reset, then sym=(s0=0,s1=7), no erase, out_ready=1.
//     -> 2 cycles later bm[0]=7, bm[1]=14, bm[2]=0, bm[3]=7; step_cnt=1.
//  2. SOFT_W=1 build, sym=(s0=1,s1=0) -> bm[0]=1, bm[1]=0, bm[2]=2, bm[3]=1 (Hamming).
//  3. sym=(3,5), erase=2'b10 -> bm[0]=3, bm[1]=4, bm[2]=3, bm[3]=4.
//     Same with erase=2'b11 -> all bm=0.
//  4. Stream 6 groups, out_ready low cycles 3-5.
//     -> in_ready low within the stall; no group lost or duplicated; bm_o/last_o stable while stalled.
//     -> order preserved; step_cnt 1..6.
//  5. Frame of 3 groups with last_i on 3rd, then a new group.
//     -> last_o=1 with step_cnt=3; the next output has step_cnt=1.
//  6. Assert reset while both stages full.
//     -> next cycle out_valid=0, bm_o=0, step_cnt_o=0; nothing emitted for the discarded groups.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: default code geometry, metric width helper and the
// per-symbol soft distance used by the branch metric unit and its reference model.
package viterbi_pkg;

    localparam int N_SYM_DEF  = 2;
    localparam int SOFT_W_DEF = 3;

    function automatic int bm_w(input int n, input int s);
        return s + $clog2(n);
    endfunction

    // Distance of soft symbol 'sym' from expected bit 'b'; an erased symbol carries no evidence.
    function automatic int sym_dist(input int sym, input logic b, input logic erase, input int soft_w);
        if (erase) begin
            return 0;
        end
        if (b) begin
            return ((1 << soft_w) - 1) - sym;
        end
        return sym;
    endfunction

endpackage

// File: rtl/bmu_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when its content leaves this cycle.
module bmu_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_reg;
    logic [DW-1:0] data_reg;
    logic          adv;

    assign adv       = !valid_reg || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    // Data only changes on a real load, so an emptied stage keeps its last payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (adv) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/bmu_soft_pipe.sv
// Soft-decision branch metric unit: masked per-symbol distances in S1, per-codeword
// sums plus frame step count in S2, with elastic valid/ready flow control.
module bmu_soft_pipe
    import viterbi_pkg::*;
#(
    parameter  int N_SYM  = N_SYM_DEF,
    parameter  int SOFT_W = SOFT_W_DEF,
    localparam int BM_W   = bm_w(N_SYM, SOFT_W),
    localparam int N_CW   = 2 ** N_SYM
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_SYM*SOFT_W-1:0] sym_i,
    input  logic [N_SYM-1:0]        erase_i,
    input  logic                    last_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CW*BM_W-1:0]    bm_o,
    output logic                    last_o,
    output logic [15:0]             step_cnt_o
);

    localparam int DW_W   = N_SYM * SOFT_W;
    localparam int S1_DW  = 2 * DW_W + 1;
    localparam int BM_ALL = N_CW * BM_W;
    localparam int S2_DW  = 16 + 1 + BM_ALL;

    logic [DW_W-1:0]   d0_next;
    logic [DW_W-1:0]   d1_next;
    logic [S1_DW-1:0]  s1_in;
    logic [S1_DW-1:0]  s1_data;
    logic              s1_valid;
    logic              s2_in_ready;
    logic [DW_W-1:0]   s1_d0;
    logic [DW_W-1:0]   s1_d1;
    logic              s1_last;
    logic [BM_ALL-1:0] bm_next;
    logic [15:0]       step_next;
    logic [S2_DW-1:0]  s2_in;
    logic [S2_DW-1:0]  s2_data;

    // Distance of each symbol to an expected '0' and to an expected '1', erasures forced to zero.
    for (genvar gi = 0; gi < N_SYM; gi++) begin : g_dist
        assign d0_next[gi*SOFT_W +: SOFT_W] =
            SOFT_W'(sym_dist(int'(sym_i[gi*SOFT_W +: SOFT_W]), 1'b0, erase_i[gi], SOFT_W));
        assign d1_next[gi*SOFT_W +: SOFT_W] =
            SOFT_W'(sym_dist(int'(sym_i[gi*SOFT_W +: SOFT_W]), 1'b1, erase_i[gi], SOFT_W));
    end

    assign s1_in = {last_i, d1_next, d0_next};

    bmu_pipe_stage #(.DW(S1_DW)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign s1_d0   = s1_data[DW_W-1:0];
    assign s1_d1   = s1_data[2*DW_W-1:DW_W];
    assign s1_last = s1_data[S1_DW-1];

    // Codeword bit j selects which precomputed distance of symbol j joins the sum.
    for (genvar gi = 0; gi < N_CW; gi++) begin : g_cw
        logic [BM_W-1:0] acc;
        always_comb begin
            acc = '0;
            for (int j = 0; j < N_SYM; j++) begin
                if (((gi >> j) & 1) != 0) begin
                    acc = acc + BM_W'(s1_d1[j*SOFT_W +: SOFT_W]);
                end else begin
                    acc = acc + BM_W'(s1_d0[j*SOFT_W +: SOFT_W]);
                end
            end
        end
        assign bm_next[gi*BM_W +: BM_W] = acc;
    end

    // S2 retains the last loaded tag and count, which decide where the next load resumes.
    assign step_next = last_o ? 16'd1 : step_cnt_o + 16'd1;
    assign s2_in     = {step_next, s1_last, bm_next};

    bmu_pipe_stage #(.DW(S2_DW)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign bm_o       = s2_data[BM_ALL-1:0];
    assign last_o     = s2_data[BM_ALL];
    assign step_cnt_o = s2_data[S2_DW-1:BM_ALL+1];

endmodule
